// File: rtl/wb_arb_pkg.sv
// Shared constants for the register-file write-back arbiter.
package wb_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_ALU0 = 2'd0;
  localparam req_idx_t REQ_ALU1 = 2'd1;
  localparam req_idx_t REQ_LSU  = 2'd2;
  localparam req_idx_t REQ_MDU  = 2'd3;

endpackage

// File: rtl/rr_dual_pick.sv
// Combinational round-robin picker: first valid requester from rr_ptr is A,
// the next valid one is B unless it targets the same nonzero register as A.
module rr_dual_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = wb_arb_pkg::NUM_REQ,
  parameter int unsigned ADDR_W  = wb_arb_pkg::ADDR_W
) (
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [1:0]                rr_ptr,
  output logic [1:0]                a_idx,
  output logic                      a_valid,
  output logic [1:0]                b_idx,
  output logic                      b_valid
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [1:0]        scan_idx;
  logic              scan_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
  end

  // Scanning stops at the candidate after A, whether or not it becomes B:
  // a same-register conflict blocks everyone behind it this cycle.
  always_comb begin
    a_valid   = 1'b0;
    a_idx     = rr_ptr;
    b_valid   = 1'b0;
    b_idx     = rr_ptr;
    scan_done = 1'b0;
    scan_idx  = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (valid[scan_idx] && !scan_done) begin
        if (!a_valid) begin
          a_valid = 1'b1;
          a_idx   = scan_idx;
        end else begin
          if ((addr_arr[scan_idx] != addr_arr[a_idx]) ||
              (addr_arr[scan_idx] == ZERO_ADDR) ||
              (addr_arr[a_idx] == ZERO_ADDR)) begin
            b_valid = 1'b1;
            b_idx   = scan_idx;
          end
          scan_done = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: four GPR requesters onto two registered write ports,
// plus a registered HI/LO write path.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = wb_arb_pkg::NUM_REQ,
  parameter int unsigned ADDR_W  = wb_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W  = wb_arb_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hilo_valid,
  input  logic                      hilo_hi_en,
  input  logic                      hilo_lo_en,
  input  logic [DATA_W-1:0]         hilo_hi_data,
  input  logic [DATA_W-1:0]         hilo_lo_data,
  output logic                      hilo_ready,
  output logic [ADDR_W-1:0]         write_addr0,
  output logic [ADDR_W-1:0]         write_addr1,
  output logic                      write_addr0_valid,
  output logic                      write_addr1_valid,
  output logic [DATA_W-1:0]         write_data0,
  output logic [DATA_W-1:0]         write_data1,
  output logic [DATA_W-1:0]         write_hilo_hi_data,
  output logic [DATA_W-1:0]         write_hilo_lo_data,
  output logic                      write_hilo_hi_data_valid,
  output logic                      write_hilo_lo_data_valid
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  req_idx_t          rr_ptr;
  req_idx_t          a_idx;
  req_idx_t          b_idx;
  logic              a_valid;
  logic              b_valid;
  logic              grant_a;
  logic              grant_b;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_dual_pick #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W)
  ) u_pick (
    .valid   (req_valid),
    .addr    (req_addr),
    .rr_ptr  (rr_ptr),
    .a_idx   (a_idx),
    .a_valid (a_valid),
    .b_idx   (b_idx),
    .b_valid (b_valid)
  );

  assign grant_a    = a_valid && !wb_stall && !rst_;
  assign grant_b    = b_valid && !wb_stall && !rst_;
  assign hilo_ready = hilo_valid && !wb_stall && !rst_;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (grant_a && (a_idx == 2'(i))) || (grant_b && (b_idx == 2'(i)));
    end
  end

  // Address/data only load on a grant so they hold between writes; $0 grants
  // still consume the request but never raise the write enable.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      rr_ptr                   <= '0;
      write_addr0              <= '0;
      write_addr1              <= '0;
      write_addr0_valid        <= 1'b0;
      write_addr1_valid        <= 1'b0;
      write_data0              <= '0;
      write_data1              <= '0;
      write_hilo_hi_data       <= '0;
      write_hilo_lo_data       <= '0;
      write_hilo_hi_data_valid <= 1'b0;
      write_hilo_lo_data_valid <= 1'b0;
    end else begin
      write_addr0_valid <= grant_a && (addr_arr[a_idx] != ZERO_ADDR);
      write_addr1_valid <= grant_b && (addr_arr[b_idx] != ZERO_ADDR);
      if (grant_a) begin
        write_addr0 <= addr_arr[a_idx];
        write_data0 <= data_arr[a_idx];
      end
      if (grant_b) begin
        write_addr1 <= addr_arr[b_idx];
        write_data1 <= data_arr[b_idx];
      end
      if (grant_b) begin
        rr_ptr <= b_idx + 2'd1;
      end else if (grant_a) begin
        rr_ptr <= a_idx + 2'd1;
      end
      write_hilo_hi_data_valid <= hilo_ready && hilo_hi_en;
      write_hilo_lo_data_valid <= hilo_ready && hilo_lo_en;
      if (hilo_ready) begin
        write_hilo_hi_data <= hilo_hi_data;
        write_hilo_lo_data <= hilo_lo_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue of expected register-file writes.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_;
  logic        wb_stall;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        hilo_valid;
  logic        hilo_hi_en;
  logic        hilo_lo_en;
  logic [31:0] hilo_hi_data;
  logic [31:0] hilo_lo_data;
  logic        hilo_ready;
  logic [4:0]  write_addr0;
  logic [4:0]  write_addr1;
  logic        write_addr0_valid;
  logic        write_addr1_valid;
  logic [31:0] write_data0;
  logic [31:0] write_data1;
  logic [31:0] write_hilo_hi_data;
  logic [31:0] write_hilo_lo_data;
  logic        write_hilo_hi_data_valid;
  logic        write_hilo_lo_data_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        hv;
    logic [31:0] hd;
    logic        lv;
    logic [31:0] ld;
  } exp_t;

  exp_t exp_q[$];

  wb_port_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .clk                      (clk),
    .rst_                     (rst_),
    .wb_stall                 (wb_stall),
    .req_valid                (req_valid),
    .req_addr                 (req_addr),
    .req_data                 (req_data),
    .req_ready                (req_ready),
    .hilo_valid               (hilo_valid),
    .hilo_hi_en               (hilo_hi_en),
    .hilo_lo_en               (hilo_lo_en),
    .hilo_hi_data             (hilo_hi_data),
    .hilo_lo_data             (hilo_lo_data),
    .hilo_ready               (hilo_ready),
    .write_addr0              (write_addr0),
    .write_addr1              (write_addr1),
    .write_addr0_valid        (write_addr0_valid),
    .write_addr1_valid        (write_addr1_valid),
    .write_data0              (write_data0),
    .write_data1              (write_data1),
    .write_hilo_hi_data       (write_hilo_hi_data),
    .write_hilo_lo_data       (write_hilo_lo_data),
    .write_hilo_hi_data_valid (write_hilo_hi_data_valid),
    .write_hilo_lo_data_valid (write_hilo_lo_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic hv, input logic [31:0] hd,
                              input logic lv, input logic [31:0] ld);
    exp_t e;
    e.v0 = v0; e.a0 = a0; e.d0 = d0;
    e.v1 = v1; e.a1 = a1; e.d1 = d1;
    e.hv = hv; e.hd = hd; e.lv = lv; e.ld = ld;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive(input int unsigned i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic step(input string tag, input logic [3:0] rdy, input logic hrdy, input exp_t e);
    exp_t w;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".hilo_ready"}, 32'(hilo_ready), 32'(hrdy));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    chk({tag, ".v0"}, 32'(write_addr0_valid), 32'(w.v0));
    chk({tag, ".v1"}, 32'(write_addr1_valid), 32'(w.v1));
    chk({tag, ".hv"}, 32'(write_hilo_hi_data_valid), 32'(w.hv));
    chk({tag, ".lv"}, 32'(write_hilo_lo_data_valid), 32'(w.lv));
    if (w.v0) begin
      chk({tag, ".a0"}, 32'(write_addr0), 32'(w.a0));
      chk({tag, ".d0"}, write_data0, w.d0);
    end
    if (w.v1) begin
      chk({tag, ".a1"}, 32'(write_addr1), 32'(w.a1));
      chk({tag, ".d1"}, write_data1, w.d1);
    end
    if (w.hv) chk({tag, ".hd"}, write_hilo_hi_data, w.hd);
    if (w.lv) chk({tag, ".ld"}, write_hilo_lo_data, w.ld);
  endtask

  task automatic clear_reqs();
    for (int unsigned i = 0; i < 4; i++) drive(i, 1'b0, 5'd0, 32'd0);
  endtask

  exp_t none;

  initial begin
    none         = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_         = 1'b1;
    wb_stall     = 1'b0;
    req_valid    = '0;
    req_addr     = '0;
    req_data     = '0;
    hilo_valid   = 1'b1;
    hilo_hi_en   = 1'b1;
    hilo_lo_en   = 1'b1;
    hilo_hi_data = 32'h1111_0001;
    hilo_lo_data = 32'h2222_0002;
    for (int unsigned i = 0; i < 4; i++) drive(i, 1'b1, 5'(i + 1), 32'h100 + i);

    // Reset held with every request valid.
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    chk("rst.hilo_ready", 32'(hilo_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rst.v0", 32'(write_addr0_valid), 32'h0);
    chk("rst.v1", 32'(write_addr1_valid), 32'h0);
    chk("rst.hv", 32'(write_hilo_hi_data_valid), 32'h0);
    chk("rst.lv", 32'(write_hilo_lo_data_valid), 32'h0);
    chk("rst.a0", 32'(write_addr0), 32'h0);
    chk("rst.a1", 32'(write_addr1), 32'h0);
    chk("rst.d0", write_data0, 32'h0);
    chk("rst.d1", write_data1, 32'h0);
    chk("rst.hd", write_hilo_hi_data, 32'h0);
    chk("rst.ld", write_hilo_lo_data, 32'h0);
    rst_       = 1'b0;
    hilo_valid = 1'b0;
    clear_reqs();

    // Round-robin from pointer 0, distinct addresses 1..4.
    for (int unsigned i = 0; i < 4; i++) drive(i, 1'b1, 5'(i + 1), 32'h10 + i);
    step("rr0", 4'b0011, 1'b0, mk(1, 5'd1, 32'h10, 1, 5'd2, 32'h11, 0, 0, 0, 0));
    drive(0, 1'b0, 5'd0, 32'd0);
    drive(1, 1'b0, 5'd0, 32'd0);
    step("rr1", 4'b1100, 1'b0, mk(1, 5'd3, 32'h12, 1, 5'd4, 32'h13, 0, 0, 0, 0));
    clear_reqs();

    // Same-address conflict: pointer back at 0, req0 wins, req1 waits.
    drive(0, 1'b1, 5'd7, 32'h70);
    drive(1, 1'b1, 5'd7, 32'h71);
    step("conf0", 4'b0001, 1'b0, mk(1, 5'd7, 32'h70, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 1'b0, 5'd0, 32'd0);
    step("conf1", 4'b0010, 1'b0, mk(1, 5'd7, 32'h71, 0, 0, 0, 0, 0, 0, 0));
    clear_reqs();

    // Single request from pointer 2.
    drive(1, 1'b1, 5'd5, 32'hA5);
    step("single", 4'b0010, 1'b0, mk(1, 5'd5, 32'hA5, 0, 0, 0, 0, 0, 0, 0));
    clear_reqs();

    // $0 discard, then two $0 writes with pointer at 3 (3 on port 0, 0 on port 1).
    drive(2, 1'b1, 5'd0, 32'hFFFF);
    step("zero", 4'b0100, 1'b0, none);
    clear_reqs();
    drive(3, 1'b1, 5'd0, 32'h33);
    drive(0, 1'b1, 5'd0, 32'h30);
    step("zero2", 4'b1001, 1'b0, none);
    clear_reqs();

    // Stall blocks GPR and HI/LO; release grants both (pointer 1 -> req0 is A).
    drive(0, 1'b1, 5'd9, 32'h90);
    hilo_valid = 1'b1;
    hilo_hi_en = 1'b1;
    hilo_lo_en = 1'b0;
    wb_stall   = 1'b1;
    step("stall", 4'b0000, 1'b0, none);
    wb_stall = 1'b0;
    step("unstall", 4'b0001, 1'b1, mk(1, 5'd9, 32'h90, 0, 0, 0, 1, 32'h1111_0001, 0, 0));
    clear_reqs();

    // HI/LO with no enables is accepted silently; then LO only.
    hilo_hi_en = 1'b0;
    step("hilo_none", 4'b0000, 1'b1, none);
    hilo_lo_en   = 1'b1;
    hilo_lo_data = 32'h2222_0BBB;
    step("hilo_lo", 4'b0000, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_0BBB));
    hilo_valid = 1'b0;
    hilo_lo_en = 1'b0;
    chk("hold.a0", 32'(write_addr0), 32'd9);
    chk("hold.d0", write_data0, 32'h90);

    // Fairness from pointer 1: grants 1,2 then 3,0.
    for (int unsigned i = 0; i < 4; i++) drive(i, 1'b1, 5'(11 + i), 32'h200 + i);
    step("fair0", 4'b0110, 1'b0, mk(1, 5'd12, 32'h201, 1, 5'd13, 32'h202, 0, 0, 0, 0));
    drive(1, 1'b0, 5'd0, 32'd0);
    drive(2, 1'b0, 5'd0, 32'd0);
    step("fair1", 4'b1001, 1'b0, mk(1, 5'd14, 32'h203, 1, 5'd11, 32'h200, 0, 0, 0, 0));
    clear_reqs();

    // Conflict blocks a later distinct-address requester (pointer 1).
    drive(1, 1'b1, 5'd6, 32'h61);
    drive(2, 1'b1, 5'd6, 32'h62);
    drive(3, 1'b1, 5'd8, 32'h83);
    step("block0", 4'b0010, 1'b0, mk(1, 5'd6, 32'h61, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 1'b0, 5'd0, 32'd0);
    step("block1", 4'b1100, 1'b0, mk(1, 5'd6, 32'h62, 1, 5'd8, 32'h83, 0, 0, 0, 0));
    clear_reqs();

    // Asynchronous reset drops a registered write immediately.
    drive(0, 1'b1, 5'd15, 32'hF0);
    step("pre_rst", 4'b0001, 1'b0, mk(1, 5'd15, 32'hF0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst_ = 1'b1;
    #1;
    chk("async_rst.v0", 32'(write_addr0_valid), 32'h0);
    chk("async_rst.a0", 32'(write_addr0), 32'h0);
    chk("async_rst.d0", write_data0, 32'h0);
    chk("async_rst.req_ready", 32'(req_ready), 32'h0);
    clear_reqs();
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
